// File: rtl/aud_adc_deser.sv
// Codec ADC serial receiver: oversamples BCLK/LRCK/ADCDAT on iCLK and rebuilds
// signed left/right samples (I2S or left-justified framing) with a channel flag.
module aud_adc_deser #(
  parameter int WS   = 16,
  parameter int MODE = 0
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iBCLK,
  input  logic                 iLRCK,
  input  logic                 iADCDAT,
  output logic signed [WS-1:0] oOut,
  output logic signed [WS-1:0] oLeft,
  output logic signed [WS-1:0] oRight,
  output logic                 oCHS,
  output logic                 oValid,
  output logic                 oErr
);

  localparam logic [4:0] WS_CNT = 5'(WS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_SHIFT,
    ST_PAD
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    bclk_sync_reg;
  logic [1:0]    lrck_sync_reg;
  logic [1:0]    dat_sync_reg;
  logic          lr_prev_reg;
  logic          lr_seen_reg;
  logic [4:0]    cnt_reg, cnt_next;
  logic [WS-1:0] shreg_reg, shreg_next;
  logic          chan_reg, chan_next;
  logic          done_next;
  logic          err_next;
  logic          start_frame;
  logic          rise;
  logic          lr_s;
  logic          dat_s;
  logic          lr_edge;

  assign rise  = bclk_sync_reg[1] & ~bclk_sync_reg[2];
  assign lr_s  = lrck_sync_reg[1];
  assign dat_s = dat_sync_reg[1];
  // No LRCK history exists at the first rise after reset, so it never counts as an edge.
  assign lr_edge = rise & lr_seen_reg & (lr_s != lr_prev_reg);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bclk_sync_reg <= '0;
      lrck_sync_reg <= '0;
      dat_sync_reg  <= '0;
      lr_prev_reg   <= 1'b0;
      lr_seen_reg   <= 1'b0;
    end else begin
      bclk_sync_reg <= {bclk_sync_reg[1:0], iBCLK};
      lrck_sync_reg <= {lrck_sync_reg[0], iLRCK};
      dat_sync_reg  <= {dat_sync_reg[0], iADCDAT};
      if (rise) begin
        lr_prev_reg <= lr_s;
        lr_seen_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shreg_next  = shreg_reg;
    chan_next   = chan_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    start_frame = 1'b0;
    if (rise) begin
      case (state_reg)
        ST_IDLE: begin
          if (lr_edge) start_frame = 1'b1;
        end
        // The edge bit itself was the I2S delay slot; this rise carries the MSB.
        ST_SKIP: begin
          if (lr_edge) begin
            err_next    = 1'b1;
            start_frame = 1'b1;
          end else begin
            shreg_next = {{(WS-1){1'b0}}, dat_s};
            cnt_next   = 5'd1;
            state_next = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (lr_edge) begin
            err_next    = 1'b1;
            start_frame = 1'b1;
          end else begin
            shreg_next = {shreg_reg[WS-2:0], dat_s};
            cnt_next   = cnt_reg + 5'd1;
            if (cnt_next == WS_CNT) begin
              done_next  = 1'b1;
              state_next = ST_PAD;
            end
          end
        end
        default: begin
          if (lr_edge) start_frame = 1'b1;
        end
      endcase
    end
    if (start_frame) begin
      chan_next = lr_s;
      if (MODE == 0) begin
        state_next = ST_SKIP;
        cnt_next   = 5'd0;
      end else begin
        state_next = ST_SHIFT;
        shreg_next = {{(WS-1){1'b0}}, dat_s};
        cnt_next   = 5'd1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      shreg_reg <= '0;
      chan_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shreg_reg <= shreg_next;
      chan_reg  <= chan_next;
    end
  end

  // Completed words land straight from the shift path so the LSB costs no extra cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oOut   <= '0;
      oLeft  <= '0;
      oRight <= '0;
      oCHS   <= 1'b0;
      oValid <= 1'b0;
      oErr   <= 1'b0;
    end else begin
      oValid <= done_next;
      oErr   <= err_next;
      if (done_next) begin
        oOut <= shreg_next;
        oCHS <= chan_reg;
        if (chan_reg) oRight <= shreg_next;
        else          oLeft  <= shreg_next;
      end
    end
  end

endmodule

// File: tb/tb_aud_adc_deser.sv
// Drives one serial stream into an I2S and a left-justified receiver and checks
// both against a frame-level model of which samples and errors must appear.
module tb_aud_adc_deser;

  localparam int WS = 16;

  typedef struct packed {
    logic          is_err;
    logic          ch;
    logic [WS-1:0] s;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bclk = 1'b0;
  logic          lrck = 1'b1;
  logic          dat [2];
  logic [WS-1:0] d_out [2];
  logic [WS-1:0] d_left [2];
  logic [WS-1:0] d_right [2];
  logic          d_chs [2];
  logic          d_valid [2];
  logic          d_err [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int half = 4;

  // Reference model state: expected event queues and expected output registers.
  ev_t           q0 [$];
  ev_t           q1 [$];
  ev_t           ev;
  logic [WS-1:0] m_out [2];
  logic [WS-1:0] m_left [2];
  logic [WS-1:0] m_right [2];
  logic          m_chs [2];
  int            err_cnt [2];
  bit            prev_pulse [2];
  bit            armed;
  bit            has;
  int            prev_len;
  logic          cur_lr;
  int            need [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      aud_adc_deser #(.WS(WS), .MODE(gi)) u_dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .iBCLK  (bclk),
        .iLRCK  (lrck),
        .iADCDAT(dat[gi]),
        .oOut   (d_out[gi]),
        .oLeft  (d_left[gi]),
        .oRight (d_right[gi]),
        .oCHS   (d_chs[gi]),
        .oValid (d_valid[gi]),
        .oErr   (d_err[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_ev(input int m, input ev_t e);
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic clear_model();
    for (int m = 0; m < 2; m++) begin
      m_out[m]   = '0;
      m_left[m]  = '0;
      m_right[m] = '0;
      m_chs[m]   = 1'b0;
    end
    armed = 1'b0;
  endtask

  task automatic bit_cycle(input logic lr, input logic d0, input logic d1);
    @(negedge clk);
    bclk   = 1'b0;
    lrck   = lr;
    dat[0] = d0;
    dat[1] = d1;
    repeat (half) @(negedge clk);
    bclk     = 1'b1;
    rise_cyc = cyc;
    repeat (half - 1) @(negedge clk);
  endtask

  // One LRCK slot of len bits. I2S puts the MSB at slot bit 1, left-justified at bit 0.
  task automatic send_slot(input logic ch, input logic [WS-1:0] s, input int len);
    logic d0, d1;
    ev_t  e;
    if (ch != cur_lr) begin
      for (int m = 0; m < 2; m++) begin
        if (armed && prev_len < need[m]) begin
          e = '{is_err: 1'b1, ch: 1'b0, s: '0};
          push_ev(m, e);
        end
        if (len >= need[m]) begin
          e = '{is_err: 1'b0, ch: ch, s: s};
          push_ev(m, e);
        end
      end
      armed    = 1'b1;
      cur_lr   = ch;
      prev_len = len;
    end else begin
      prev_len += len;
    end
    for (int k = 0; k < len; k++) begin
      d1 = (k < WS) ? s[WS-1-k] : 1'($urandom_range(0, 1));
      d0 = (k >= 1 && k <= WS) ? s[WS-k] : 1'($urandom_range(0, 1));
      bit_cycle(ch, d0, d1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    clear_model();
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d_rst_out", m),   d_out[m],   0);
      check($sformatf("m%0d_rst_left", m),  d_left[m],  0);
      check($sformatf("m%0d_rst_right", m), d_right[m], 0);
      check($sformatf("m%0d_rst_chs", m),   d_chs[m],   0);
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pulse[0] = 1'b0;
      prev_pulse[1] = 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (d_valid[m] || d_err[m]) begin
          check($sformatf("m%0d_pulse_width", m), prev_pulse[m], 0);
          check($sformatf("m%0d_latency", m), cyc - rise_cyc, 3);
          check($sformatf("m%0d_valid_err_overlap", m), d_valid[m] & d_err[m], 0);
          has = (m == 0) ? (q0.size() != 0) : (q1.size() != 0);
          check($sformatf("m%0d_event_expected", m), has, 1);
          if (has) begin
            if (m == 0) ev = q0.pop_front();
            else        ev = q1.pop_front();
            check($sformatf("m%0d_event_kind", m), d_err[m], ev.is_err);
            if (!ev.is_err) begin
              m_out[m] = ev.s;
              m_chs[m] = ev.ch;
              if (ev.ch) m_right[m] = ev.s;
              else       m_left[m]  = ev.s;
            end
          end
          if (d_err[m]) err_cnt[m]++;
        end
        check($sformatf("m%0d_out", m),   d_out[m],   m_out[m]);
        check($sformatf("m%0d_left", m),  d_left[m],  m_left[m]);
        check($sformatf("m%0d_right", m), d_right[m], m_right[m]);
        check($sformatf("m%0d_chs", m),   d_chs[m],   m_chs[m]);
        prev_pulse[m] = d_valid[m] | d_err[m];
      end
    end
  end

  initial begin : stim
    int            e0, e1;
    logic [WS-1:0] l0, l1;
    need[0]    = WS + 1;
    need[1]    = WS;
    err_cnt[0] = 0;
    err_cnt[1] = 0;
    prev_len   = 0;
    cur_lr     = 1'b1;
    dat[0]     = 1'b0;
    dat[1]     = 1'b0;
    clear_model();

    repeat (4) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d_reset_out", m),   d_out[m],   0);
      check($sformatf("m%0d_reset_left", m),  d_left[m],  0);
      check($sformatf("m%0d_reset_right", m), d_right[m], 0);
      check($sformatf("m%0d_reset_chs", m),   d_chs[m],   0);
      check($sformatf("m%0d_reset_valid", m), d_valid[m], 0);
      check($sformatf("m%0d_reset_err", m),   d_err[m],   0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Startup: 7 bits with no LRCK edge, then I2S-style 32-bit slots.
    send_slot(1'b1, 16'h5A5A, 7);
    send_slot(1'b0, 16'h1234, 32);
    send_slot(1'b1, 16'hFEDC, 32);
    repeat (8) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d_i2s_left", m),  d_left[m],  16'h1234);
      check($sformatf("m%0d_i2s_right", m), d_right[m], 16'hFEDC);
      check($sformatf("m%0d_i2s_noerr", m), err_cnt[m], 0);
    end

    // 16-bit slots: complete only for left-justified framing.
    send_slot(1'b0, 16'h8000, 16);
    send_slot(1'b1, 16'h7FFF, 16);
    repeat (8) @(negedge clk);
    check("lj_left",  d_left[1],  16'h8000);
    check("lj_right", d_right[1], 16'h7FFF);
    check("lj_chs",   d_chs[1],   1);

    // Short left frame of 10 bits.
    e0 = err_cnt[0];
    e1 = err_cnt[1];
    l0 = d_left[0];
    l1 = d_left[1];
    send_slot(1'b0, 16'(($urandom)), 10);
    send_slot(1'b1, 16'h00FF, 32);
    repeat (8) @(negedge clk);
    check("short_m0_errs", err_cnt[0] - e0, 2);
    check("short_m1_errs", err_cnt[1] - e1, 1);
    check("short_m0_left_kept", d_left[0], l0);
    check("short_m1_left_kept", d_left[1], l1);
    check("short_m0_right", d_right[0], 16'h00FF);
    check("short_m1_right", d_right[1], 16'h00FF);

    // Reset in the middle of a left word.
    send_slot(1'b0, 16'(($urandom)), 8);
    do_reset();
    e0 = err_cnt[0];
    e1 = err_cnt[1];
    send_slot(1'b0, 16'(($urandom)), 20);
    send_slot(1'b1, 16'(($urandom)), 32);
    send_slot(1'b0, 16'h0A0A, 32);
    repeat (8) @(negedge clk);
    check("rst_m0_left", d_left[0], 16'h0A0A);
    check("rst_m1_left", d_left[1], 16'h0A0A);
    check("rst_m0_noerr", err_cnt[0] - e0, 0);
    check("rst_m1_noerr", err_cnt[1] - e1, 0);

    // Random stereo traffic with variable slot padding at BCLK = iCLK/4.
    half = 2;
    for (int f = 0; f < 200; f++) begin
      send_slot(1'b1, 16'(($urandom)), int'($urandom_range(WS + 1, WS + 8)));
      send_slot(1'b0, 16'(($urandom)), int'($urandom_range(WS + 1, WS + 8)));
    end
    repeat (40) @(negedge clk);
    check("m0_all_events_seen", q0.size(), 0);
    check("m1_all_events_seen", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
